// File: rtl/mult_req_arbiter_pkg.sv
// rtl/mult_req_arbiter_pkg.sv - shared FSM state encoding and requester ids
package mult_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic REQ0_ID = 1'b0;
  localparam logic REQ1_ID = 1'b1;

endpackage

// File: rtl/mult_req_arbiter_rr_arbiter2.sv
// rtl/mult_req_arbiter_rr_arbiter2.sv - two-way round-robin grant, one-hot or zero
module rr_arbiter2
  import mult_req_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On contention the requester that was not served last wins.
  assign grant[0] = req[0] & (~req[1] | (last_grant == REQ1_ID));
  assign grant[1] = req[1] & (~req[0] | (last_grant == REQ0_ID));

endmodule

// File: rtl/mult_req_arbiter.sv
// rtl/mult_req_arbiter.sv - shares one sequential multiplier core between two requesters
module mult_req_arbiter
  import mult_req_arbiter_pkg::*;
#(
  parameter int W        = 8,
  parameter int TIMEOUT  = 64,
  parameter int FASTPATH = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           resp_valid,
  output logic           resp_id,
  output logic [2*W-1:0] resp_p,
  output logic           resp_err,
  input  logic           resp_ready,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  input  logic           mul_done,
  output logic           busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t         r_state;
  logic           r_last;
  logic           r_id;
  logic           r_done_q;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_p;
  logic           r_err;
  logic           r_valid;
  logic           r_start;
  logic [CW-1:0]  r_cnt;

  logic [1:0]     w_grant;
  logic           w_acc;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic           w_fast;
  logic           w_done_rise;

  rr_arbiter2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (r_last),
    .grant      (w_grant)
  );

  assign req0_ready  = (r_state == ST_IDLE) & w_grant[0];
  assign req1_ready  = (r_state == ST_IDLE) & w_grant[1];
  assign w_acc       = req0_ready | req1_ready;
  assign w_sel_a     = w_grant[1] ? req1_a : req0_a;
  assign w_sel_b     = w_grant[1] ? req1_b : req0_b;
  assign w_fast      = (FASTPATH != 0) && ((w_sel_a == '0) || (w_sel_b == '0));
  // Only a fresh rising edge completes; a level left high by the previous op is ignored.
  assign w_done_rise = mul_done & ~r_done_q;

  assign resp_valid = r_valid;
  assign resp_id    = r_id;
  assign resp_p     = r_p;
  assign resp_err   = r_err;
  assign mul_start  = r_start;
  assign mul_a      = r_a;
  assign mul_b      = r_b;
  assign busy       = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last   <= REQ1_ID;
      r_id     <= REQ0_ID;
      r_done_q <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
      r_start  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done_q <= mul_done;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_a    <= w_sel_a;
            r_b    <= w_sel_b;
            r_id   <= w_grant[1] ? REQ1_ID : REQ0_ID;
            r_last <= w_grant[1] ? REQ1_ID : REQ0_ID;
            r_err  <= 1'b0;
            if (w_fast) begin
              r_p     <= '0;
              r_valid <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_start <= 1'b1;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done_rise) begin
            r_p     <= mul_p;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_p     <= '0;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_req_arbiter.sv
// tb/tb_mult_req_arbiter.sv - directed scoreboard bench with a 9-cycle multiplier core model
module tb_mult_req_arbiter;

  typedef struct {
    logic        id;
    logic [15:0] p;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_id, resp_err;
  logic [15:0] resp_p;
  logic        resp_ready = 1'b0;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        busy;

  logic        hang = 1'b0;
  logic [3:0]  m_cnt = '0;
  logic        m_done = 1'b0;
  logic [15:0] m_p = '0;
  int          n_start = 0;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mult_req_arbiter #(.W(8), .TIMEOUT(16), .FASTPATH(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_p(resp_p), .resp_err(resp_err),
    .resp_ready(resp_ready),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(m_p), .mul_done(m_done),
    .busy(busy)
  );

  // Core model: done rises 9 cycles after start, stays high until the next start.
  always @(posedge clk) begin
    if (mul_start) begin
      n_start <= n_start + 1;
      m_cnt   <= 4'd9;
      m_done  <= 1'b0;
      m_p     <= 16'(mul_a) * 16'(mul_b);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1 && !hang) m_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
  endtask

  task automatic wait_accept(input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic err, input bit push);
    exp_t e;
    bit   ok = 0;
    set_req(id, a, b);
    for (int n = 0; n < 200; n++) begin
      #1;
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin ok = 1; break; end
      @(negedge clk);
    end
    chk($sformatf("accept_req%0d", id), 32'(ok), 32'd1);
    e.id  = (id == 1);
    e.p   = err ? 16'd0 : 16'(a) * 16'(b);
    e.err = err;
    if (push) sb.push_back(e);
    @(negedge clk);
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_resp();
    exp_t e;
    bit   ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (resp_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("resp_arrives", 32'(ok), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("resp_id", 32'(resp_id), 32'(e.id));
      chk("resp_p", 32'(resp_p), 32'(e.p));
      chk("resp_err", 32'(resp_err), 32'(e.err));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int s0;
    int lat;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_resp_p", 32'(resp_p), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Pair after reset: last_grant=1, so req0 first.
    set_req(0, 8'd12, 8'd12);
    set_req(1, 8'd255, 8'd2);
    #1;
    chk("pair1_r0_ready", 32'(req0_ready), 32'd1);
    chk("pair1_r1_ready", 32'(req1_ready), 32'd0);
    wait_accept(0, 8'd12, 8'd12, 1'b0, 1);
    wait_resp();
    wait_accept(1, 8'd255, 8'd2, 1'b0, 1);
    wait_resp();

    // Single req0 op through the core.
    s0 = n_start;
    wait_accept(0, 8'd8, 8'd5, 1'b0, 1);
    chk("issue_mul_a", 32'(mul_a), 32'd8);
    chk("issue_mul_b", 32'(mul_b), 32'd5);
    wait_resp();
    chk("single_starts", 32'(n_start - s0), 32'd1);

    // Pair after req0 served: req1 wins first.
    set_req(0, 8'd12, 8'd12);
    set_req(1, 8'd255, 8'd2);
    #1;
    chk("pair2_r1_ready", 32'(req1_ready), 32'd1);
    chk("pair2_r0_ready", 32'(req0_ready), 32'd0);
    wait_accept(1, 8'd255, 8'd2, 1'b0, 1);
    wait_resp();
    wait_accept(0, 8'd12, 8'd12, 1'b0, 1);
    wait_resp();

    // Fast path: answered one cycle after accept with no core start.
    s0 = n_start;
    wait_accept(1, 8'd0, 8'd77, 1'b0, 1);
    chk("fast_valid_1cyc", 32'(resp_valid), 32'd1);
    wait_resp();
    chk("fast_no_start", 32'(n_start - s0), 32'd0);

    // Watchdog: core never completes.
    hang = 1'b1;
    wait_accept(0, 8'd15, 8'd3, 1'b1, 1);
    chk("to_issue", 32'(mul_start), 32'd1);
    lat = 0;
    for (int n = 0; n < 100 && !resp_valid; n++) begin
      @(negedge clk);
      lat++;
    end
    chk("to_latency", 32'(lat), 32'd17);
    wait_resp();
    hang = 1'b0;
    wait_accept(1, 8'd7, 8'd6, 1'b0, 1);
    wait_resp();

    // Backpressure: response held while req1 waits.
    wait_accept(0, 8'd255, 8'd255, 1'b0, 1);
    set_req(1, 8'd3, 8'd4);
    for (int n = 0; n < 100 && !resp_valid; n++) begin
      #1;
      chk("bp_r1_wait_ready", 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_p", 32'(resp_p), 32'd65025);
      chk("bp_r1_ready", 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    wait_resp();
    wait_accept(1, 8'd3, 8'd4, 1'b0, 1);
    wait_resp();

    // Reset in WAIT discards the operation.
    wait_accept(0, 8'd8, 8'd5, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_start", 32'(mul_start), 32'd0);
    chk("mid_rst_p", 32'(resp_p), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("mid_no_resp", 32'(seen), 32'd0);
    wait_accept(0, 8'd3, 8'd3, 1'b0, 1);
    wait_resp();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
